fifo_wr_ctrl: RTL and testbench
===============================

// Module: fifo_wr_ctrl
// PURPOSE
//  Write-domain controller for the async camera-to-VGA pixel FIFO, successor to the basic write-pointer block.
//  Adds internal N-stage read-pointer synchroniser, gray->binary conversion, fill level, almost_full
//  threshold, write-accept strobe and sticky overflow flag. Drives the dual-port RAM write address.
//  Sits in wclk (camera PCLK) domain; the read-side controller supplies g_rptr.
// PARAMETERS
//  ADDR_WIDTH   9   RAM address bits; DEPTH = 2**ADDR_WIDTH; pointers are ADDR_WIDTH+1 bits; legal >= 2
//  SYNC_STAGES  2   flops in g_rptr synchroniser; legal 2..4
//  AF_MARGIN    4   almost_full when free entries <= AF_MARGIN; legal 1..DEPTH-1
// PORTS
//  wclk         in   1             write clock
//  wrst_n       in   1             asynchronous, active-low reset
//  w_en         in   1             write request from producer
//  ovf_clr      in   1             clears sticky overflow
//  g_rptr       in   ADDR_WIDTH+1  gray read pointer from rclk domain (unsynchronised)
//  w_accept     out  1             combinational: w_en & ~full; RAM write enable
//  waddr        out  ADDR_WIDTH    RAM write address = b_wptr[ADDR_WIDTH-1:0]
//  b_wptr       out  ADDR_WIDTH+1  binary write pointer (registered)
//  g_wptr       out  ADDR_WIDTH+1  gray write pointer to read domain (registered)
//  full         out  1             FIFO full (registered)
//  almost_full  out  1             level >= DEPTH-AF_MARGIN (registered)
//  wlevel       out  ADDR_WIDTH+1  conservative occupancy 0..DEPTH (registered)
//  overflow     out  1             sticky: write attempted while full
// BEHAVIOUR
//  - Reset (async assert, sync release by wclk): b_wptr, g_wptr, sync flops, full, almost_full,
//    wlevel, overflow all 0; w_accept=0 while w_en=0.
//  - Synchroniser: g_rptr shifted through SYNC_STAGES flops; g_rptr_s = last stage.
//    b_rptr_s = gray2bin(g_rptr_s), combinational (MSB copy, XOR-prefix downward).
//  - b_wptr_next = b_wptr + w_accept (mod 2**(ADDR_WIDTH+1)); g_wptr_next = b_wptr_next ^ (b_wptr_next>>1).
//    Each edge: b_wptr<=b_wptr_next, g_wptr<=g_wptr_next. g_wptr changes at most one bit per cycle.
//  - full <= (g_wptr_next == {~g_rptr_s[AW:AW-1], g_rptr_s[AW-2:0]}); asserts the cycle after the
//    write that fills the last entry, so no write is ever accepted while full.
//  - lvl_next = b_wptr_next - b_rptr_s (AW+1-bit modular); wlevel <= lvl_next;
//    almost_full <= (lvl_next >= DEPTH-AF_MARGIN). full implies almost_full and wlevel==DEPTH.
//  - Read-side drain visible after SYNC_STAGES+1 wclk edges (sync + flag register); level/full
//    are pessimistic, never optimistic.
//  - overflow: set when w_en & full; cleared when ovf_clr & ~(w_en & full); set wins on simultaneity.
//  - Write while full: dropped, pointers hold, w_accept=0.
//  - Wrap: pointers wrap 2**(AW+1)-1 -> 0 with no flag glitch; waddr wraps DEPTH-1 -> 0.
//  - Reset mid-fill: immediate return to reset values; read side must be reset concurrently.
// TESTING (ADDR_WIDTH=3, DEPTH=8, SYNC_STAGES=2, AF_MARGIN=2)
//  1 Reset: wrst_n=0 mid-run -> all outputs 0 same cycle without clock; first write after release: waddr=0.
//  2 Fill: g_rptr=0, w_en=1 for 9 cycles -> 8 accepts, full=1 after 8th, b_wptr=8, g_wptr=4'b1100,
//    wlevel=8, 9th not accepted, overflow=1.
//  3 Threshold: g_rptr=0, 6 writes -> almost_full=1 when wlevel=6, 0 at wlevel=5; full stays 0.
//  4 Drain while full: g_rptr=4'b0010 (bin 3) -> full 0 and wlevel=5 exactly 3 wclk edges later.
//  5 Wrap: model reader advancing g_rptr; stream 40 writes -> b_wptr wraps 15->0, g_wptr 1-bit
//    changes only, no data loss, wlevel matches model every cycle.
//  6 Overflow clear: ovf_clr=1 with w_en=1 & full=1 -> overflow stays 1; ovf_clr with full=0 -> 0.

Source files
------------

// File: rtl/fifo_wr_ctrl.sv
// fifo_wr_ctrl: write-side pointer, level and flag controller for the async camera-to-VGA pixel FIFO
module fifo_wr_ctrl #(
    parameter int ADDR_WIDTH  = 9,
    parameter int SYNC_STAGES = 2,
    parameter int AF_MARGIN   = 4
) (
    input  logic                  wclk,
    input  logic                  wrst_n,
    input  logic                  w_en,
    input  logic                  ovf_clr,
    input  logic [ADDR_WIDTH:0]   g_rptr,
    output logic                  w_accept,
    output logic [ADDR_WIDTH-1:0] waddr,
    output logic [ADDR_WIDTH:0]   b_wptr,
    output logic [ADDR_WIDTH:0]   g_wptr,
    output logic                  full,
    output logic                  almost_full,
    output logic [ADDR_WIDTH:0]   wlevel,
    output logic                  overflow
);
    localparam int AW = ADDR_WIDTH;
    localparam logic [AW:0] AF_LEVEL = (AW+1)'((1 << AW) - AF_MARGIN);

    logic [AW:0] sync_q [SYNC_STAGES];
    logic [AW:0] sync_d [SYNC_STAGES];
    logic [AW:0] g_rptr_s, b_rptr_s;
    logic [AW:0] b_wptr_q, b_wptr_d, g_wptr_q, g_wptr_d, wlevel_q, wlevel_d;
    logic        full_q, full_d, af_q, af_d, ovf_q, ovf_d;

    // Shift the raw read pointer through the synchroniser chain
    always_comb begin
        sync_d[0] = g_rptr;
        for (int i = 1; i < SYNC_STAGES; i++) sync_d[i] = sync_q[i-1];
    end

    // Decode the synchronised read pointer and compute next pointers, level and flags
    always_comb begin
        g_rptr_s = sync_q[SYNC_STAGES-1];
        b_rptr_s = '0;
        for (int i = 0; i <= AW; i++) b_rptr_s[i] = ^(g_rptr_s >> i);
        w_accept = w_en & ~full_q;
        b_wptr_d = b_wptr_q + {{AW{1'b0}}, w_accept};
        g_wptr_d = b_wptr_d ^ (b_wptr_d >> 1);
        full_d   = g_wptr_d == {~g_rptr_s[AW:AW-1], g_rptr_s[AW-2:0]};
        wlevel_d = b_wptr_d - b_rptr_s;
        af_d     = wlevel_d >= AF_LEVEL;
        ovf_d    = (w_en & full_q) | (ovf_q & ~ovf_clr);
    end

    // State registers; wrst_n is expected to be released synchronously to wclk upstream
    always_ff @(posedge wclk or negedge wrst_n) begin
        if (!wrst_n) begin
            for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
            b_wptr_q <= '0;
            g_wptr_q <= '0;
            wlevel_q <= '0;
            full_q   <= 1'b0;
            af_q     <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= sync_d[i];
            b_wptr_q <= b_wptr_d;
            g_wptr_q <= g_wptr_d;
            wlevel_q <= wlevel_d;
            full_q   <= full_d;
            af_q     <= af_d;
            ovf_q    <= ovf_d;
        end
    end

    assign waddr       = b_wptr_q[AW-1:0];
    assign b_wptr      = b_wptr_q;
    assign g_wptr      = g_wptr_q;
    assign wlevel      = wlevel_q;
    assign full        = full_q;
    assign almost_full = af_q;
    assign overflow    = ovf_q;
endmodule

// File: tb/tb_fifo_wr_ctrl.sv
// tb_fifo_wr_ctrl: randomized self-checking bench for fifo_wr_ctrl against a count-based FIFO model
module tb_fifo_wr_ctrl;
    logic       wclk = 1'b0;
    logic       wrst_n = 1'b0;
    logic       w_en = 1'b0;
    logic       ovf_clr = 1'b0;
    logic [3:0] g_rptr = '0;
    logic       w_accept, full, almost_full, overflow;
    logic [2:0] waddr;
    logic [3:0] b_wptr, g_wptr, wlevel;

    int checks = 0;
    int failures = 0;

    // Model: total writes accepted, total reads done, and the read counts seen by each sync stage
    int wcnt, rcnt, m_lvl;
    int rhist[$];
    bit m_full, m_af, m_ovf, m_acc;

    fifo_wr_ctrl #(.ADDR_WIDTH(3), .SYNC_STAGES(2), .AF_MARGIN(2)) dut (
        .wclk(wclk), .wrst_n(wrst_n), .w_en(w_en), .ovf_clr(ovf_clr), .g_rptr(g_rptr),
        .w_accept(w_accept), .waddr(waddr), .b_wptr(b_wptr), .g_wptr(g_wptr),
        .full(full), .almost_full(almost_full), .wlevel(wlevel), .overflow(overflow)
    );

    always #5 wclk = ~wclk;

    function automatic logic [3:0] gray(input int v);
        logic [3:0] b;
        b = v[3:0];
        return b ^ (b >> 1);
    endfunction

    task automatic model_reset();
        wcnt = 0; rcnt = 0; m_lvl = 0;
        rhist = {0, 0};
        m_full = 0; m_af = 0; m_ovf = 0; m_acc = 0;
    endtask

    task automatic tick();
        g_rptr = gray(rcnt);
        @(posedge wclk);
        m_acc = w_en && !m_full;
        m_ovf = (w_en && m_full) || (m_ovf && !ovf_clr);
        if (m_acc) wcnt++;
        m_lvl = wcnt - rhist.pop_front();
        rhist.push_back(rcnt);
        m_full = m_lvl == 8;
        m_af = m_lvl >= 6;
        @(negedge wclk);
        #1;
    endtask

    task automatic do_reset();
        w_en = 0; ovf_clr = 0; rcnt = 0; g_rptr = '0; wrst_n = 0;
        model_reset();
        @(negedge wclk);
        wrst_n = 1;
        #1;
    endtask

    task automatic test_reset();
        do_reset();
        w_en = 1;
        repeat (5) tick();
        if (b_wptr !== 4'd5) begin failures++; $display("FAIL pre_reset_b_wptr got=%0d exp=5", b_wptr); end checks++;
        #2;
        wrst_n = 0; w_en = 0;
        #1;
        model_reset();
        if (b_wptr !== 4'd0) begin failures++; $display("FAIL reset_b_wptr got=%0d exp=0", b_wptr); end checks++;
        if (g_wptr !== 4'd0) begin failures++; $display("FAIL reset_g_wptr got=%0d exp=0", g_wptr); end checks++;
        if (waddr !== 3'd0) begin failures++; $display("FAIL reset_waddr got=%0d exp=0", waddr); end checks++;
        if (wlevel !== 4'd0) begin failures++; $display("FAIL reset_wlevel got=%0d exp=0", wlevel); end checks++;
        if (full !== 1'b0) begin failures++; $display("FAIL reset_full got=%b exp=0", full); end checks++;
        if (almost_full !== 1'b0) begin failures++; $display("FAIL reset_af got=%b exp=0", almost_full); end checks++;
        if (overflow !== 1'b0) begin failures++; $display("FAIL reset_ovf got=%b exp=0", overflow); end checks++;
        if (w_accept !== 1'b0) begin failures++; $display("FAIL reset_w_accept got=%b exp=0", w_accept); end checks++;
        @(negedge wclk);
        wrst_n = 1; w_en = 1;
        #1;
        if (waddr !== 3'd0) begin failures++; $display("FAIL first_waddr got=%0d exp=0", waddr); end checks++;
        if (w_accept !== 1'b1) begin failures++; $display("FAIL first_accept got=%b exp=1", w_accept); end checks++;
        tick();
        if (b_wptr !== 4'd1) begin failures++; $display("FAIL first_b_wptr got=%0d exp=1", b_wptr); end checks++;
        w_en = 0;
    endtask

    task automatic test_fill();
        do_reset();
        w_en = 1;
        #1;
        for (int i = 0; i < 9; i++) begin
            if (w_accept !== (i < 8)) begin failures++; $display("FAIL fill_accept[%0d] got=%b exp=%b", i, w_accept, i < 8); end checks++;
            tick();
        end
        if (full !== 1'b1) begin failures++; $display("FAIL fill_full got=%b exp=1", full); end checks++;
        if (b_wptr !== 4'd8) begin failures++; $display("FAIL fill_b_wptr got=%0d exp=8", b_wptr); end checks++;
        if (g_wptr !== 4'b1100) begin failures++; $display("FAIL fill_g_wptr got=%b exp=1100", g_wptr); end checks++;
        if (wlevel !== 4'd8) begin failures++; $display("FAIL fill_wlevel got=%0d exp=8", wlevel); end checks++;
        if (almost_full !== 1'b1) begin failures++; $display("FAIL fill_af got=%b exp=1", almost_full); end checks++;
        if (overflow !== 1'b1) begin failures++; $display("FAIL fill_ovf got=%b exp=1", overflow); end checks++;
        w_en = 0;
    endtask

    task automatic test_drain();
        w_en = 0;
        rcnt = 3;
        tick();
        tick();
        if (full !== 1'b1) begin failures++; $display("FAIL drain_early_full got=%b exp=1", full); end checks++;
        tick();
        if (full !== 1'b0) begin failures++; $display("FAIL drain_full got=%b exp=0", full); end checks++;
        if (wlevel !== 4'd5) begin failures++; $display("FAIL drain_wlevel got=%0d exp=5", wlevel); end checks++;
        if (almost_full !== 1'b0) begin failures++; $display("FAIL drain_af got=%b exp=0", almost_full); end checks++;
    endtask

    task automatic test_threshold();
        do_reset();
        w_en = 1;
        for (int i = 1; i <= 6; i++) begin
            tick();
            if (wlevel !== 4'(i)) begin failures++; $display("FAIL thr_wlevel[%0d] got=%0d exp=%0d", i, wlevel, i); end checks++;
            if (almost_full !== (i >= 6)) begin failures++; $display("FAIL thr_af[%0d] got=%b exp=%b", i, almost_full, i >= 6); end checks++;
            if (full !== 1'b0) begin failures++; $display("FAIL thr_full[%0d] got=%b exp=0", i, full); end checks++;
        end
        w_en = 0;
    endtask

    task automatic test_ovf_clr();
        do_reset();
        w_en = 1;
        repeat (8) tick();
        ovf_clr = 1;
        tick();
        if (overflow !== 1'b1) begin failures++; $display("FAIL ovf_set_wins got=%b exp=1", overflow); end checks++;
        w_en = 0; ovf_clr = 0; rcnt = 8;
        repeat (3) tick();
        if (full !== 1'b0) begin failures++; $display("FAIL ovf_drained_full got=%b exp=0", full); end checks++;
        if (overflow !== 1'b1) begin failures++; $display("FAIL ovf_sticky got=%b exp=1", overflow); end checks++;
        ovf_clr = 1;
        tick();
        if (overflow !== 1'b0) begin failures++; $display("FAIL ovf_cleared got=%b exp=0", overflow); end checks++;
        ovf_clr = 0;
    endtask

    task automatic test_wrap();
        int acc = 0;
        int cyc = 0;
        bit saw_wrap = 0;
        logic [3:0] prev_g, prev_b;
        do_reset();
        while (acc < 40 && cyc < 1000) begin
            w_en = $urandom_range(0, 3) != 0;
            if (rcnt < wcnt && $urandom_range(0, 2) == 0) rcnt++;
            #1;
            if (w_accept !== (w_en && !m_full)) begin failures++; $display("FAIL wrap_accept[%0d] got=%b exp=%b", cyc, w_accept, w_en && !m_full); end checks++;
            if (waddr !== 3'(wcnt)) begin failures++; $display("FAIL wrap_waddr[%0d] got=%0d exp=%0d", cyc, waddr, wcnt % 8); end checks++;
            prev_g = g_wptr;
            prev_b = b_wptr;
            tick();
            if (m_acc) acc++;
            if (prev_b == 4'd15 && b_wptr == 4'd0) saw_wrap = 1;
            if (b_wptr !== 4'(wcnt)) begin failures++; $display("FAIL wrap_b_wptr[%0d] got=%0d exp=%0d", cyc, b_wptr, wcnt % 16); end checks++;
            if (g_wptr !== gray(wcnt)) begin failures++; $display("FAIL wrap_g_wptr[%0d] got=%b exp=%b", cyc, g_wptr, gray(wcnt)); end checks++;
            if ($countones(g_wptr ^ prev_g) > 1) begin failures++; $display("FAIL wrap_gray_step[%0d] got=%b from=%b", cyc, g_wptr, prev_g); end checks++;
            if (wlevel !== 4'(m_lvl)) begin failures++; $display("FAIL wrap_wlevel[%0d] got=%0d exp=%0d", cyc, wlevel, m_lvl); end checks++;
            if (full !== m_full) begin failures++; $display("FAIL wrap_full[%0d] got=%b exp=%b", cyc, full, m_full); end checks++;
            if (almost_full !== m_af) begin failures++; $display("FAIL wrap_af[%0d] got=%b exp=%b", cyc, almost_full, m_af); end checks++;
            if (overflow !== m_ovf) begin failures++; $display("FAIL wrap_ovf[%0d] got=%b exp=%b", cyc, overflow, m_ovf); end checks++;
            cyc++;
        end
        if (acc != 40) begin failures++; $display("FAIL wrap_timeout accepted=%0d exp=40", acc); end checks++;
        if (!saw_wrap) begin failures++; $display("FAIL wrap_seen got=0 exp=1"); end checks++;
        w_en = 0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        model_reset();
        @(negedge wclk);
        test_reset();
        test_fill();
        test_drain();
        test_threshold();
        test_ovf_clr();
        test_wrap();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
